rf_wb_buffer: RTL and testbench

- Writeback-side producer for the dual-write-port integer register file.
- Accepts up to two in-order results per cycle from the two execution lanes and buffers them in a small circular queue.
- Drains up to two entries per cycle onto rf write bus 0 (older) and rf write bus 1 (younger).
- Optionally exposes forwarding lookups so decode can read results not yet written back.

---
 rtl/rf_wb_pkg.sv | 18 +
 rtl/rf_wb_fifo.sv | 71 +++++++
 rtl/rf_wb_buffer.sv | 117 +++++++++++
 tb/tb_rf_wb_buffer.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_wb_pkg.sv
// Shared constants, entry type and sizing helper for the writeback buffer.
package rf_wb_pkg;

    localparam int NR_GPR = 32;
    localparam int XLEN   = 64;
    localparam int AW     = $clog2(NR_GPR);

    typedef struct packed {
        logic [AW-1:0]   waddr;
        logic [XLEN-1:0] wdata;
    } wb_entry_t;

    // Occupancy must represent 0..depth inclusive.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/rf_wb_fifo.sv
// Two-in / two-out circular buffer of writeback entries.
// With RF_WB_FWD_EN defined it also exports its storage and head pointer for lookups.
module rf_wb_fifo
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = occ_width(DEPTH)
) (
    input  logic            clock_i,
    input  logic            reset_i,
    input  logic [1:0]      enq_cnt_i,
    input  wb_entry_t       enq_0_i,
    input  wb_entry_t       enq_1_i,
    input  logic [1:0]      deq_cnt_i,
    output wb_entry_t       head_0_o,
    output wb_entry_t       head_1_o,
    output logic [CW-1:0]   count_o
`ifdef RF_WB_FWD_EN
    ,
    output logic [PW-1:0]   head_ptr_o,
    output wb_entry_t [DEPTH-1:0] mem_o
`endif
);

    wb_entry_t     mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        head_d  = head_q + PW'(deq_cnt_i);
        tail_d  = tail_q + PW'(enq_cnt_i);
        count_d = count_q + CW'(enq_cnt_i) - CW'(deq_cnt_i);
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clock_i) begin
        if (enq_cnt_i != 2'd0) mem_q[tail_q] <= enq_0_i;
        if (enq_cnt_i == 2'd2) mem_q[tail_q + PW'(1)] <= enq_1_i;
    end

    assign head_0_o = mem_q[head_q];
    assign head_1_o = mem_q[head_q + PW'(1)];
    assign count_o  = count_q;

`ifdef RF_WB_FWD_EN
    assign head_ptr_o = head_q;
    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_o[i] = mem_q[i];
    end
`endif

    overflow_a: assert property (@(posedge clock_i) disable iff (reset_i)
        count_d <= CW'(DEPTH));
    underflow_a: assert property (@(posedge clock_i) disable iff (reset_i)
        CW'(deq_cnt_i) <= count_q);

endmodule

// File: rtl/rf_wb_buffer.sv
// Writeback buffer feeding the dual-write-port register file: x0 filter, same-address squash.
// Optional forwarding lookups are built only when RF_WB_FWD_EN is defined.
module rf_wb_buffer
    import rf_wb_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int CW = occ_width(DEPTH)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_0_valid,
    input  logic [AW-1:0]   in_0_waddr,
    input  logic [XLEN-1:0] in_0_wdata,
    input  logic            in_1_valid,
    input  logic [AW-1:0]   in_1_waddr,
    input  logic [XLEN-1:0] in_1_wdata,
    output logic            in_ready,
    input  logic            drain_en,
    output logic            rf_bus_0_wen,
    output logic [AW-1:0]   rf_bus_0_waddr,
    output logic [XLEN-1:0] rf_bus_0_wdata,
    output logic            rf_bus_1_wen,
    output logic [AW-1:0]   rf_bus_1_waddr,
    output logic [XLEN-1:0] rf_bus_1_wdata,
    input  logic [AW-1:0]   fwd_addr_0,
    input  logic [AW-1:0]   fwd_addr_1,
    output logic            fwd_hit_0,
    output logic            fwd_hit_1,
    output logic [XLEN-1:0] fwd_data_0,
    output logic [XLEN-1:0] fwd_data_1,
    output logic [CW-1:0]   count
);

    wb_entry_t     lane_0, lane_1, enq_0, enq_1, head_0, head_1;
    logic          keep_0, keep_1;
    logic          wen_0_raw, wen_1, same_addr;
    logic [1:0]    enq_cnt, deq_cnt;
    logic [CW-1:0] occ;

    assign lane_0 = '{waddr: in_0_waddr, wdata: in_0_wdata};
    assign lane_1 = '{waddr: in_1_waddr, wdata: in_1_wdata};
    assign keep_0 = in_0_valid && (in_0_waddr != '0);
    assign keep_1 = in_1_valid && (in_1_waddr != '0);

    // Conservative: a drain in the same cycle does not open room for a new pair.
    assign in_ready = occ <= CW'(DEPTH - 2);
    assign enq_cnt  = in_ready ? ({1'b0, keep_0} + {1'b0, keep_1}) : 2'd0;
    assign enq_0    = keep_0 ? lane_0 : lane_1;
    assign enq_1    = lane_1;

    assign wen_0_raw = drain_en && (occ != '0);
    assign wen_1     = drain_en && (occ >= CW'(2));
    assign same_addr = wen_1 && (head_0.waddr == head_1.waddr);
    assign deq_cnt   = {1'b0, wen_0_raw} + {1'b0, wen_1};

    // A squashed older write is still consumed; only the younger value reaches the file.
    assign rf_bus_0_wen   = wen_0_raw && !same_addr;
    assign rf_bus_0_waddr = head_0.waddr;
    assign rf_bus_0_wdata = head_0.wdata;
    assign rf_bus_1_wen   = wen_1;
    assign rf_bus_1_waddr = head_1.waddr;
    assign rf_bus_1_wdata = head_1.wdata;
    assign count          = occ;

`ifdef RF_WB_FWD_EN
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0]          head_ptr;
    wb_entry_t [DEPTH-1:0]  mem;
`endif

    rf_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock_i   (clock),
        .reset_i   (reset),
        .enq_cnt_i (enq_cnt),
        .enq_0_i   (enq_0),
        .enq_1_i   (enq_1),
        .deq_cnt_i (deq_cnt),
        .head_0_o  (head_0),
        .head_1_o  (head_1),
        .count_o   (occ)
`ifdef RF_WB_FWD_EN
        ,
        .head_ptr_o(head_ptr),
        .mem_o     (mem)
`endif
    );

`ifdef RF_WB_FWD_EN
    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        fwd_hit_0  = 1'b0;
        fwd_hit_1  = 1'b0;
        fwd_data_0 = '0;
        fwd_data_1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i) < occ) begin
                if ((fwd_addr_0 != '0) && (mem[head_ptr + PW'(i)].waddr == fwd_addr_0)) begin
                    fwd_hit_0  = 1'b1;
                    fwd_data_0 = mem[head_ptr + PW'(i)].wdata;
                end
                if ((fwd_addr_1 != '0) && (mem[head_ptr + PW'(i)].waddr == fwd_addr_1)) begin
                    fwd_hit_1  = 1'b1;
                    fwd_data_1 = mem[head_ptr + PW'(i)].wdata;
                end
            end
        end
    end
`else
    logic unused_fwd;
    assign unused_fwd = ^{fwd_addr_0, fwd_addr_1};
    assign fwd_hit_0  = 1'b0;
    assign fwd_hit_1  = 1'b0;
    assign fwd_data_0 = '0;
    assign fwd_data_1 = '0;
`endif

endmodule

// File: tb/tb_rf_wb_buffer.sv
// Self-checking bench for rf_wb_buffer: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_rf_wb_buffer;
    import rf_wb_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = occ_width(DEPTH);
`ifdef RF_WB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic            in_0_valid, in_1_valid, drain_en;
    logic [AW-1:0]   in_0_waddr, in_1_waddr, fwd_addr_0, fwd_addr_1;
    logic [XLEN-1:0] in_0_wdata, in_1_wdata;
    logic            in_ready, rf_bus_0_wen, rf_bus_1_wen, fwd_hit_0, fwd_hit_1;
    logic [AW-1:0]   rf_bus_0_waddr, rf_bus_1_waddr;
    logic [XLEN-1:0] rf_bus_0_wdata, rf_bus_1_wdata, fwd_data_0, fwd_data_1;
    logic [CW-1:0]   count;

    rf_wb_buffer #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .in_0_valid(in_0_valid), .in_0_waddr(in_0_waddr), .in_0_wdata(in_0_wdata),
        .in_1_valid(in_1_valid), .in_1_waddr(in_1_waddr), .in_1_wdata(in_1_wdata),
        .in_ready(in_ready), .drain_en(drain_en),
        .rf_bus_0_wen(rf_bus_0_wen), .rf_bus_0_waddr(rf_bus_0_waddr), .rf_bus_0_wdata(rf_bus_0_wdata),
        .rf_bus_1_wen(rf_bus_1_wen), .rf_bus_1_waddr(rf_bus_1_waddr), .rf_bus_1_wdata(rf_bus_1_wdata),
        .fwd_addr_0(fwd_addr_0), .fwd_addr_1(fwd_addr_1),
        .fwd_hit_0(fwd_hit_0), .fwd_hit_1(fwd_hit_1),
        .fwd_data_0(fwd_data_0), .fwd_data_1(fwd_data_1),
        .count(count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;
    } ment_t;

    ment_t mq[$];
    int checks = 0;
    int errors = 0;

    logic            e_rdy, e_w0, e_w1, e_h0, e_h1;
    logic [XLEN-1:0] e_fd0, e_fd1;

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [XLEN-1:0] d1,
                         input logic de);
        in_0_valid = v0; in_0_waddr = a0; in_0_wdata = d0;
        in_1_valid = v1; in_1_waddr = a1; in_1_wdata = d1;
        drain_en = de;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        drive(0, '0, '0, 0, '0, '0, 0);
        fwd_addr_0 = '0;
        fwd_addr_1 = '0;
        mq.delete();
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Expected outputs from the pending-write list and current inputs.
    task automatic model_eval();
        e_rdy = (DEPTH - mq.size()) >= 2;
        e_w1  = drain_en && (mq.size() >= 2);
        e_w0  = drain_en && (mq.size() >= 1) && !(e_w1 && mq[0].a == mq[1].a);
        e_h0 = 1'b0; e_h1 = 1'b0; e_fd0 = '0; e_fd1 = '0;
        if (FWD) begin
            foreach (mq[i]) begin
                if (fwd_addr_0 != '0 && mq[i].a == fwd_addr_0) begin e_h0 = 1'b1; e_fd0 = mq[i].d; end
                if (fwd_addr_1 != '0 && mq[i].a == fwd_addr_1) begin e_h1 = 1'b1; e_fd1 = mq[i].d; end
            end
        end
    endtask

    // Edge update: retire up to two oldest, then append accepted non-x0 results in lane order.
    task automatic model_clock();
        int n;
        int deq;
        n = mq.size();
        deq = drain_en ? ((n >= 2) ? 2 : n) : 0;
        repeat (deq) void'(mq.pop_front());
        if ((DEPTH - n) >= 2) begin
            if (in_0_valid && in_0_waddr != '0) mq.push_back('{a: in_0_waddr, d: in_0_wdata});
            if (in_1_valid && in_1_waddr != '0) mq.push_back('{a: in_1_waddr, d: in_1_wdata});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1, 5, 64'h55, 1, 6, 64'h66, 1);
        fwd_addr_0 = 5;
        fwd_addr_1 = 6;
        #3;
        checks++;
        if ({count, rf_bus_0_wen, rf_bus_1_wen, fwd_hit_0, fwd_hit_1} !== {CW'(0), 4'b0000}) begin
            errors++;
            $display("FAIL reset_outputs: got count=%0d wen=%b%b hit=%b%b, expected count=0 wen=00 hit=00",
                     count, rf_bus_0_wen, rf_bus_1_wen, fwd_hit_0, fwd_hit_1);
        end
        @(posedge clock); #1;
        checks++;
        if (count !== CW'(0) || rf_bus_0_wen !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold: got count=%0d wen0=%b, expected count=0 wen0=0", count, rf_bus_0_wen);
        end
        @(negedge clock);
        reset = 1'b0;
        drive(0, '0, '0, 0, '0, '0, 0);
        fwd_addr_0 = '0;
        fwd_addr_1 = '0;
        #2;
        checks++;
        if (in_ready !== 1'b1 || count !== CW'(0)) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b count=%0d, expected in_ready=1 count=0", in_ready, count);
        end
    endtask

    task automatic test_single_write();
        do_reset();
        @(negedge clock);
        drive(1, 5, 64'h1111, 0, '0, '0, 1);
        #2;
        checks++;
        if (rf_bus_0_wen !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: got wen0=%b, expected 0 before enqueue edge", rf_bus_0_wen);
        end
        @(negedge clock);
        drive(0, '0, '0, 0, '0, '0, 1);
        #2;
        checks++;
        if ({rf_bus_0_wen, rf_bus_0_waddr, rf_bus_0_wdata} !== {1'b1, 5'd5, 64'h1111}) begin
            errors++;
            $display("FAIL single_bus0: got wen=%b addr=%0d data=%h, expected wen=1 addr=5 data=1111",
                     rf_bus_0_wen, rf_bus_0_waddr, rf_bus_0_wdata);
        end
        checks++;
        if (rf_bus_1_wen !== 1'b0 || count !== CW'(1)) begin
            errors++;
            $display("FAIL single_bus1: got wen1=%b count=%0d, expected wen1=0 count=1", rf_bus_1_wen, count);
        end
        @(negedge clock); #2;
        checks++;
        if (count !== CW'(0)) begin
            errors++;
            $display("FAIL single_empty: got count=%0d, expected 0", count);
        end
    endtask

    task automatic test_same_addr();
        do_reset();
        @(negedge clock);
        drive(1, 7, 64'hA, 1, 7, 64'hB, 1);
        @(negedge clock);
        drive(0, '0, '0, 0, '0, '0, 1);
        #2;
        checks++;
        if ({count, rf_bus_0_wen, rf_bus_1_wen, rf_bus_1_waddr, rf_bus_1_wdata} !==
            {CW'(2), 1'b0, 1'b1, 5'd7, 64'hB}) begin
            errors++;
            $display("FAIL same_addr_squash: got count=%0d wen=%b%b addr1=%0d data1=%h, expected count=2 wen=01 addr1=7 data1=b",
                     count, rf_bus_0_wen, rf_bus_1_wen, rf_bus_1_waddr, rf_bus_1_wdata);
        end
        @(negedge clock); #2;
        checks++;
        if (count !== CW'(0)) begin
            errors++;
            $display("FAIL same_addr_consumed: got count=%0d, expected 0", count);
        end
    endtask

    task automatic test_x0_filter();
        do_reset();
        @(negedge clock);
        drive(1, 0, 64'hDEAD, 1, 3, 64'h3, 0);
        @(negedge clock);
        drive(0, '0, '0, 0, '0, '0, 0);
        #2;
        checks++;
        if (count !== CW'(1)) begin
            errors++;
            $display("FAIL x0_count: got count=%0d, expected 1", count);
        end
        drain_en = 1'b1;
        #1;
        checks++;
        if ({rf_bus_0_wen, rf_bus_0_waddr, rf_bus_0_wdata, rf_bus_1_wen} !== {1'b1, 5'd3, 64'h3, 1'b0}) begin
            errors++;
            $display("FAIL x0_drain: got wen0=%b addr0=%0d data0=%h wen1=%b, expected wen0=1 addr0=3 data0=3 wen1=0",
                     rf_bus_0_wen, rf_bus_0_waddr, rf_bus_0_wdata, rf_bus_1_wen);
        end
        @(negedge clock);
        drain_en = 1'b0;
    endtask

    task automatic test_fill_backpressure();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            drive(1, AW'(2*k+1), XLEN'(256 + 2*k), 1, AW'(2*k+2), XLEN'(257 + 2*k), 0);
        end
        @(negedge clock);
        drive(1, 20, 64'hBAD, 1, 21, 64'hBAD, 0);
        #2;
        checks++;
        if (count !== CW'(8) || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: got count=%0d in_ready=%b, expected count=8 in_ready=0", count, in_ready);
        end
        @(negedge clock);
        drive(0, '0, '0, 0, '0, '0, 0);
        #2;
        checks++;
        if (count !== CW'(8)) begin
            errors++;
            $display("FAIL fill_ignored: got count=%0d, expected 8", count);
        end
        for (int k = 0; k < 4; k++) begin
            drain_en = 1'b1;
            #1;
            checks++;
            if ({count, in_ready, rf_bus_0_wen, rf_bus_0_waddr, rf_bus_0_wdata, rf_bus_1_wen, rf_bus_1_waddr, rf_bus_1_wdata} !==
                {CW'(8 - 2*k), (k != 0), 1'b1, AW'(2*k+1), XLEN'(256 + 2*k), 1'b1, AW'(2*k+2), XLEN'(257 + 2*k)}) begin
                errors++;
                $display("FAIL drain_order step %0d: got count=%0d rdy=%b a0=%0d d0=%h a1=%0d d1=%h, expected count=%0d rdy=%b a0=%0d d0=%h a1=%0d d1=%h",
                         k, count, in_ready, rf_bus_0_waddr, rf_bus_0_wdata, rf_bus_1_waddr, rf_bus_1_wdata,
                         8 - 2*k, (k != 0), 2*k+1, 256 + 2*k, 2*k+2, 257 + 2*k);
            end
            @(negedge clock);
        end
        drain_en = 1'b0;
        #2;
        checks++;
        if (count !== CW'(0) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty: got count=%0d in_ready=%b, expected 0 and 1", count, in_ready);
        end
    endtask

    task automatic test_forwarding();
        do_reset();
        @(negedge clock);
        drive(1, 9, 64'h1, 1, 9, 64'h2, 0);
        fwd_addr_0 = 9;
        fwd_addr_1 = 0;
        #2;
        checks++;
        if (fwd_hit_0 !== 1'b0) begin
            errors++;
            $display("FAIL fwd_same_cycle: got hit0=%b, expected 0", fwd_hit_0);
        end
        @(negedge clock);
        drive(0, '0, '0, 0, '0, '0, 0);
        #2;
        checks++;
        if ({fwd_hit_0, fwd_data_0, fwd_hit_1} !== {FWD, (FWD ? 64'h2 : 64'h0), 1'b0}) begin
            errors++;
            $display("FAIL fwd_youngest: got hit0=%b data0=%h hit1=%b, expected hit0=%b data0=%h hit1=0",
                     fwd_hit_0, fwd_data_0, fwd_hit_1, FWD, (FWD ? 64'h2 : 64'h0));
        end
        fwd_addr_1 = 4;
        drain_en = 1'b1;
        #1;
        checks++;
        if ({fwd_hit_0, fwd_hit_1} !== {FWD, 1'b0}) begin
            errors++;
            $display("FAIL fwd_draining: got hit0=%b hit1=%b, expected hit0=%b hit1=0", fwd_hit_0, fwd_hit_1, FWD);
        end
        @(negedge clock);
        drain_en = 1'b0;
        #2;
        checks++;
        if (fwd_hit_0 !== 1'b0 || count !== CW'(0)) begin
            errors++;
            $display("FAIL fwd_after_drain: got hit0=%b count=%0d, expected 0 and 0", fwd_hit_0, count);
        end
        fwd_addr_0 = '0;
        fwd_addr_1 = '0;
    endtask

    task automatic test_reset_mid_drain();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            drive(1, AW'(2*k+1), XLEN'(k), 1, AW'(2*k+2), XLEN'(k + 16), 0);
        end
        @(negedge clock);
        drive(0, '0, '0, 0, '0, '0, 1);
        #1;
        checks++;
        if (count !== CW'(6) || rf_bus_0_wen !== 1'b1) begin
            errors++;
            $display("FAIL mid_drain_pre: got count=%0d wen0=%b, expected count=6 wen0=1", count, rf_bus_0_wen);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({count, rf_bus_0_wen, rf_bus_1_wen} !== {CW'(0), 2'b00}) begin
            errors++;
            $display("FAIL mid_drain_async: got count=%0d wen=%b%b, expected count=0 wen=00",
                     count, rf_bus_0_wen, rf_bus_1_wen);
        end
        @(posedge clock);
        checks++;
        if (rf_bus_0_wen !== 1'b0 || rf_bus_1_wen !== 1'b0) begin
            errors++;
            $display("FAIL mid_drain_edge: got wen=%b%b at edge, expected 00", rf_bus_0_wen, rf_bus_1_wen);
        end
        @(negedge clock);
        reset = 1'b0;
        drain_en = 1'b0;
        mq.delete();
        #2;
        checks++;
        if (count !== CW'(0) || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_drain_release: got count=%0d in_ready=%b, expected 0 and 1", count, in_ready);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clock);
            drive($urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 9) < 7, AW'($urandom_range(0, 7)), {$urandom, $urandom},
                  $urandom_range(0, 9) < 4);
            fwd_addr_0 = AW'($urandom_range(0, 7));
            fwd_addr_1 = AW'($urandom_range(0, 7));
            #2;
            model_eval();
            checks++;
            if ({count, in_ready, rf_bus_0_wen, rf_bus_1_wen, fwd_hit_0, fwd_hit_1} !==
                {CW'(mq.size()), e_rdy, e_w0, e_w1, e_h0, e_h1}) begin
                errors++;
                $display("FAIL rand_ctl cyc %0d: got count=%0d rdy=%b wen=%b%b hit=%b%b, expected count=%0d rdy=%b wen=%b%b hit=%b%b",
                         cyc, count, in_ready, rf_bus_0_wen, rf_bus_1_wen, fwd_hit_0, fwd_hit_1,
                         mq.size(), e_rdy, e_w0, e_w1, e_h0, e_h1);
            end
            if (e_w0) begin
                checks++;
                if ({rf_bus_0_waddr, rf_bus_0_wdata} !== {mq[0].a, mq[0].d}) begin
                    errors++;
                    $display("FAIL rand_bus0 cyc %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                             cyc, rf_bus_0_waddr, rf_bus_0_wdata, mq[0].a, mq[0].d);
                end
            end
            if (e_w1) begin
                checks++;
                if ({rf_bus_1_waddr, rf_bus_1_wdata} !== {mq[1].a, mq[1].d}) begin
                    errors++;
                    $display("FAIL rand_bus1 cyc %0d: got addr=%0d data=%h, expected addr=%0d data=%h",
                             cyc, rf_bus_1_waddr, rf_bus_1_wdata, mq[1].a, mq[1].d);
                end
            end
            if (e_h0 || e_h1) begin
                checks++;
                if ((e_h0 && fwd_data_0 !== e_fd0) || (e_h1 && fwd_data_1 !== e_fd1)) begin
                    errors++;
                    $display("FAIL rand_fwd cyc %0d: got data0=%h data1=%h, expected data0=%h data1=%h",
                             cyc, fwd_data_0, fwd_data_1, e_fd0, e_fd1);
                end
            end
            @(posedge clock);
            model_clock();
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_same_addr();
        test_x0_filter();
        test_fill_backpressure();
        test_forwarding();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
